// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, quotient/remainder
// sign restoration on exit.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    output logic            neg_a_o,
    output logic            neg_b_o,
    input  logic [XLEN-1:0] raw_quo_i,
    input  logic [XLEN-1:0] raw_rem_i,
    input  logic            neg_a_q_i,
    input  logic            neg_b_q_i,
    input  logic            div_zero_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    assign neg_a_o = signed_i & src_a_i[XLEN-1];
    assign neg_b_o = signed_i & src_b_i[XLEN-1];
    assign abs_a_o = neg_a_o ? (~src_a_i + 1'b1) : src_a_i;
    assign abs_b_o = neg_b_o ? (~src_b_i + 1'b1) : src_b_i;

    // A zero divisor must keep the all-ones quotient, so negation is suppressed.
    assign quo_o = ((neg_a_q_i ^ neg_b_q_i) & ~div_zero_i) ? (~raw_quo_i + 1'b1) : raw_quo_i;
    assign rem_o = neg_a_q_i ? (~raw_rem_i + 1'b1) : raw_rem_i;

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with stall and flush handling.
// Optional fast path for divide-by-zero and signed overflow: DIV_FAST_SPECIAL_EN.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E_div_start,
    input  logic [1:0]      E_div_op,
    input  logic [XLEN-1:0] E_src_a,
    input  logic [XLEN-1:0] E_src_b,
    input  logic            E_flush,
    output logic            E_div_stall,
    output logic            E_div_valid,
    output logic [XLEN-1:0] E_div_result
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DIV_ITERS - 1);

    div_state_e       state_q;
    div_op_e          op_q;
    logic             neg_a_q, neg_b_q;
    logic [XLEN-1:0]  quo_q, dvs_q, rem_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    div_op_e          op_in;
    logic             in_signed, neg_a_in, neg_b_in;
    logic [XLEN-1:0]  abs_a, abs_b, fix_quo, fix_rem, quo_n, rem_n;
    logic [XLEN:0]    shifted, diff;
    logic             take;

    assign op_in     = div_op_e'(E_div_op);
    assign in_signed = op_is_signed(op_in);

    // shifted is the 33-bit partial remainder after the left shift.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[XLEN];
    assign rem_n   = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], take};

    div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .src_a_i    (E_src_a),
        .src_b_i    (E_src_b),
        .signed_i   (in_signed),
        .abs_a_o    (abs_a),
        .abs_b_o    (abs_b),
        .neg_a_o    (neg_a_in),
        .neg_b_o    (neg_b_in),
        .raw_quo_i  (quo_n),
        .raw_rem_i  (rem_n),
        .neg_a_q_i  (neg_a_q),
        .neg_b_q_i  (neg_b_q),
        .div_zero_i (dvs_q == '0),
        .quo_o      (fix_quo),
        .rem_o      (fix_rem)
    );

`ifdef DIV_FAST_SPECIAL_EN
    logic            b_zero, sgn_ovf;
    logic [XLEN-1:0] special_res;
    assign b_zero  = (E_src_b == '0);
    assign sgn_ovf = in_signed && (E_src_a == {1'b1, {(XLEN-1){1'b0}}}) && (E_src_b == '1);
    always_comb begin
        special_res = '0;
        if (op_is_rem(op_in)) special_res = b_zero ? E_src_a : '0;
        else                  special_res = b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= DIV_OP_DIV;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (E_flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (E_div_start) begin
                        op_q    <= op_in;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        quo_q   <= abs_a;
                        dvs_q   <= abs_b;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
`ifdef DIV_FAST_SPECIAL_EN
                        if (b_zero || sgn_ovf) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result_q <= op_is_rem(op_q) ? fix_rem : fix_quo;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign E_div_stall  = rst_n & (((state_q == IDLE) & E_div_start & ~E_flush) |
                                   (state_q == CALC));
    assign E_div_valid  = (state_q == DONE) & ~E_flush;
    assign E_div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks them.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        E_div_start = 1'b0;
    logic [1:0]  E_div_op = 2'b00;
    logic [31:0] E_src_a = '0;
    logic [31:0] E_src_b = '0;
    logic        E_flush = 1'b0;
    logic        E_div_stall, E_div_valid;
    logic [31:0] E_div_result;

    div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .E_div_start  (E_div_start),
        .E_div_op     (E_div_op),
        .E_src_a      (E_src_a),
        .E_src_b      (E_src_b),
        .E_flush      (E_flush),
        .E_div_stall  (E_div_stall),
        .E_div_valid  (E_div_valid),
        .E_div_result (E_div_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Architectural reference: plain integer arithmetic plus the RISC-V zero-divisor rule.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        if (rst_n && E_div_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", E_div_result, e.res);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit hold_chk, input string tag);
        exp_t e;
        int   n;
        int   lat;
        lat   = latency(op, a, b);
        @(posedge clk);
        #1;
        E_div_start = 1'b1;
        E_div_op    = op;
        E_src_a     = a;
        E_src_b     = b;
        e.res       = ref_div(op, a, b);
        e.cyc       = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        chk({tag, "_stall_c0"}, {31'h0, E_div_stall}, 32'd1);
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        E_src_a     = $urandom;
        E_src_b     = $urandom;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!E_div_stall) break;
            n++;
            // Starts during CALC must be ignored.
            if (k == 4) E_div_start = 1'b1;
            if (k == 5) E_div_start = 1'b0;
        end
        E_div_start = 1'b0;
        chk({tag, "_stall_cycles"}, n, lat);
        if (hold_chk) begin
            @(negedge clk);
            chk({tag, "_valid_after_done"}, {31'h0, E_div_valid}, 32'd0);
            chk({tag, "_result_hold"}, E_div_result, e.res);
        end
    endtask

    initial begin
        int hi;
        logic [1:0]  op;
        logic [31:0] a, b;

        E_div_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_stall", {31'h0, E_div_stall}, 32'd0);
        chk("reset_valid", {31'h0, E_div_valid}, 32'd0);
        chk("reset_result", E_div_result, 32'd0);
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        rst_n = 1'b1;

        run_div(2'b01, 32'd100, 32'd7, 1'b1, "divu_100_7");
        run_div(2'b11, 32'd100, 32'd7, 1'b1, "remu_100_7");
        run_div(2'b00, -32'sd100, 32'd7, 1'b0, "div_m100_7");
        run_div(2'b10, -32'sd100, 32'd7, 1'b0, "rem_m100_7");
        run_div(2'b00, 32'd5, 32'd0, 1'b1, "div_5_0");
        run_div(2'b10, 32'd5, 32'd0, 1'b0, "rem_5_0");
        run_div(2'b01, 32'd5, 32'd0, 1'b0, "divu_5_0");
        run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");

        // Flush around cycle 10 of CALC.
        @(posedge clk);
        #1;
        E_div_start = 1'b1;
        E_div_op    = 2'b01;
        E_src_a     = 32'd1000;
        E_src_b     = 32'd3;
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        E_flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_during", {31'h0, E_div_stall}, 32'd1);
        @(posedge clk);
        #1;
        E_flush = 1'b0;
        @(negedge clk);
        chk("flush_stall_after", {31'h0, E_div_stall}, 32'd0);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (E_div_stall) hi++;
        end
        chk("flush_stays_idle", hi, 0);
        run_div(2'b01, 32'd1000, 32'd3, 1'b0, "after_flush");

        // Start together with flush is ignored.
        @(posedge clk);
        #1;
        E_div_start = 1'b1;
        E_flush     = 1'b1;
        @(negedge clk);
        chk("start_flush_stall", {31'h0, E_div_stall}, 32'd0);
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        E_flush     = 1'b0;
        @(negedge clk);
        chk("start_flush_idle", {31'h0, E_div_stall}, 32'd0);
        repeat (5) @(negedge clk);

        // Back-to-back divides.
        run_div(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, "b2b_first");
        run_div(2'b01, 32'd9, 32'd3, 1'b0, "b2b_second");

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_div(op, a, b, (i % 4) == 0, "rand");
        end

        // Reset in the middle of CALC.
        @(posedge clk);
        #1;
        E_div_start = 1'b1;
        E_div_op    = 2'b00;
        E_src_a     = 32'd77;
        E_src_b     = 32'd5;
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", {31'h0, E_div_stall}, 32'd0);
        chk("midreset_valid", {31'h0, E_div_valid}, 32'd0);
        chk("midreset_result", E_div_result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_div(2'b10, 32'd77, 32'd5, 1'b1, "after_reset");

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid: got no valid, expected result 0x%08h at cycle %0d",
                     e.res, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
